lab3_sweep: RTL and testbench
=============================

LAB3_SWEEP -- requirements
Module: lab3_sweep

Interface
REQ-001 SHALL have parameter SETTLE, default 1, meaning the number of cycles (1..15) each input vector is held before sampling.
REQ-002 SHALL have port CL2947MP_clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port CL2947MP_rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port CL2947MP_start  input  1  sweep request, sampled only in IDLE.
REQ-005 SHALL have port CL2947MP_expected  input  16  golden truth table; bit i is the expected output for vector i.
REQ-006 SHALL have port CL2947MP_in_g  input  1  combinational output of the 4-input function under test.
REQ-007 SHALL have ports CL2947MP_w, CL2947MP_x, CL2947MP_y, CL2947MP_z  output  1 each  registered stimulus to the function under test.
REQ-008 SHALL have port CL2947MP_busy  output  1  high while a sweep is in progress.
REQ-009 SHALL have port CL2947MP_done  output  1  single-cycle completion pulse.
REQ-010 SHALL have port CL2947MP_captured  output  16  sampled truth table.
REQ-011 SHALL have port CL2947MP_err_count  output  5  count of mismatching bits (0..16).
REQ-012 SHALL have port CL2947MP_first_err_idx  output  4  index of the lowest mismatching vector; 0 when there is no mismatch.
REQ-013 SHALL have port CL2947MP_mismatch  output  1  high when err_count is non-zero, valid from done onward.

Function
REQ-014 SHALL implement FSM states IDLE, DRIVE, SAMPLE and DONE.
REQ-015 SHALL, in IDLE with start=1, latch expected, clear captured, err_count, first_err_idx and mismatch, set idx=0, and enter DRIVE.
REQ-016 SHALL drive {w,x,y,z} = idx[3:0], with w as MSB, from registers in DRIVE and SAMPLE.
REQ-017 SHALL stay in DRIVE for exactly SETTLE cycles, then enter SAMPLE for exactly 1 cycle.
REQ-018 SHALL, in SAMPLE, write captured[idx]<=in_g; on captured bit != latched expected bit, increment err_count and, on the first such bit, load first_err_idx=idx.
REQ-019 SHALL, in SAMPLE with idx<15, increment idx and return to DRIVE; with idx==15, enter DONE.
REQ-020 SHALL hold done=1 for the single DONE cycle, then return to IDLE; captured, err_count, first_err_idx and mismatch hold until the next accepted start.
REQ-021 SHALL give latency: start accepted at edge T puts done=1 in cycle T+1+16*(SETTLE+1), i.e. T+33 for SETTLE=1.
REQ-022 SHALL assert busy in DRIVE, SAMPLE and DONE, and deassert it in IDLE.
REQ-023 SHALL ignore start outside IDLE; start held high through DONE starts a new sweep only from IDLE, on the next cycle.
REQ-024 SHALL ignore changes to expected after start is accepted.
REQ-025 SHALL hold {w,x,y,z} at 0 in IDLE.

Reset
REQ-026 SHALL, with rst=1 at a rising edge, enter IDLE and zero idx, settle counter, w, x, y, z, busy, done, captured, err_count, first_err_idx and mismatch.
REQ-027 SHALL give rst priority over start, including mid-sweep; the partial result is discarded.

Configuration
REQ-028 SHALL, with macro LAB3_SWEEP_STOP_ON_ERR_EN defined, go from SAMPLE directly to DONE on the first mismatching bit; captured bits above that index stay 0 and err_count=1.
REQ-029 SHALL, without LAB3_SWEEP_STOP_ON_ERR_EN, always sweep all 16 vectors per REQ-019.

Verification
REQ-030 SHALL verify: in_g=w^x^y^z, expected=16'h6996, SETTLE=1, start at T -> done at T+33, captured=16'h6996, err_count=0, mismatch=0.
REQ-031 SHALL verify: same loopback, expected=16'h6997 -> err_count=1, first_err_idx=0, mismatch=1.
REQ-032 SHALL verify: rst pulsed at T+10 mid-sweep -> all outputs 0 next cycle; a new start then completes with captured=16'h6996.
REQ-033 SHALL verify: start re-pulsed at T+5 and expected changed to 16'h0000 at T+5 -> ignored; single done at T+33, err_count=0.
REQ-034 SHALL verify: SETTLE=3 -> done at T+65, each vector visible on w..z for 4 cycles.
REQ-035 SHALL verify: LAB3_SWEEP_STOP_ON_ERR_EN defined, expected=16'h0000, XOR loopback -> done after vector 1, first_err_idx=1, captured=16'h0002, err_count=1.

Source files
------------

// File: rtl/lab3_sweep.sv
// lab3_sweep: exhaustive truth-table sweep of a 4-input combinational function.
// Drives all 16 input vectors on {w,x,y,z} (w = MSB), holds each vector for
// SETTLE cycles, samples the function output, and compares it against a
// latched golden table.
// Optional build macro LAB3_SWEEP_STOP_ON_ERR_EN: end the sweep on the first
// mismatching vector instead of sweeping all 16 vectors.
module lab3_sweep #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        CL2947MP_clk,
  input  logic        CL2947MP_rst,
  input  logic        CL2947MP_start,
  input  logic [15:0] CL2947MP_expected,
  input  logic        CL2947MP_in_g,
  output logic        CL2947MP_w,
  output logic        CL2947MP_x,
  output logic        CL2947MP_y,
  output logic        CL2947MP_z,
  output logic        CL2947MP_busy,
  output logic        CL2947MP_done,
  output logic [15:0] CL2947MP_captured,
  output logic [4:0]  CL2947MP_err_count,
  output logic [3:0]  CL2947MP_first_err_idx,
  output logic        CL2947MP_mismatch
);

  // Last value of the settle counter before moving on to SAMPLE.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state_r;
  logic [3:0]  idx_r;
  logic [3:0]  settle_r;
  logic [15:0] exp_r;

  logic        bit_err_s;
  logic [4:0]  err_next_s;
  logic        finish_s;

  // Compare the sampled bit with the latched golden bit and decide whether
  // the current SAMPLE cycle ends the sweep.
  always_comb begin
    bit_err_s  = CL2947MP_in_g ^ exp_r[idx_r];
    err_next_s = CL2947MP_err_count + 5'(bit_err_s);
`ifdef LAB3_SWEEP_STOP_ON_ERR_EN
    finish_s   = bit_err_s || (idx_r == 4'd15);
`else
    finish_s   = (idx_r == 4'd15);
`endif
  end

  // Sweep controller: state, stimulus registers and result registers.
  always_ff @(posedge CL2947MP_clk) begin
    if (CL2947MP_rst) begin
      state_r                <= IDLE;
      idx_r                  <= 4'd0;
      settle_r               <= 4'd0;
      exp_r                  <= 16'd0;
      {CL2947MP_w, CL2947MP_x, CL2947MP_y, CL2947MP_z} <= 4'd0;
      CL2947MP_busy          <= 1'b0;
      CL2947MP_done          <= 1'b0;
      CL2947MP_captured      <= 16'd0;
      CL2947MP_err_count     <= 5'd0;
      CL2947MP_first_err_idx <= 4'd0;
      CL2947MP_mismatch      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          {CL2947MP_w, CL2947MP_x, CL2947MP_y, CL2947MP_z} <= 4'd0;
          CL2947MP_done <= 1'b0;
          if (CL2947MP_start) begin
            // Golden table is frozen here; later changes are ignored.
            exp_r                  <= CL2947MP_expected;
            CL2947MP_captured      <= 16'd0;
            CL2947MP_err_count     <= 5'd0;
            CL2947MP_first_err_idx <= 4'd0;
            CL2947MP_mismatch      <= 1'b0;
            idx_r                  <= 4'd0;
            settle_r               <= 4'd0;
            CL2947MP_busy          <= 1'b1;
            state_r                <= DRIVE;
          end else begin
            CL2947MP_busy <= 1'b0;
          end
        end
        DRIVE: begin
          if (settle_r == SETTLE_LAST) begin
            settle_r <= 4'd0;
            state_r  <= SAMPLE;
          end else begin
            settle_r <= settle_r + 4'd1;
          end
        end
        SAMPLE: begin
          CL2947MP_captured[idx_r] <= CL2947MP_in_g;
          if (bit_err_s) begin
            CL2947MP_err_count <= err_next_s;
            // Error count still zero means this is the first mismatch.
            if (CL2947MP_err_count == 5'd0) begin
              CL2947MP_first_err_idx <= idx_r;
            end
          end
          if (finish_s) begin
            {CL2947MP_w, CL2947MP_x, CL2947MP_y, CL2947MP_z} <= 4'd0;
            CL2947MP_done     <= 1'b1;
            CL2947MP_mismatch <= (err_next_s != 5'd0);
            state_r           <= DONE;
          end else begin
            // Next vector goes out together with the return to DRIVE.
            idx_r   <= idx_r + 4'd1;
            {CL2947MP_w, CL2947MP_x, CL2947MP_y, CL2947MP_z} <= idx_r + 4'd1;
            state_r <= DRIVE;
          end
        end
        DONE: begin
          CL2947MP_done <= 1'b0;
          CL2947MP_busy <= 1'b0;
          state_r       <= IDLE;
        end
        default: begin
          {CL2947MP_w, CL2947MP_x, CL2947MP_y, CL2947MP_z} <= 4'd0;
          CL2947MP_done <= 1'b0;
          CL2947MP_busy <= 1'b0;
          state_r       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lab3_sweep.sv
// Testbench for lab3_sweep: XOR loopback as the function under test.
// A scoreboard queue holds the expected result of each sweep; a monitor
// compares it whenever the SETTLE=1 instance pulses done. A second
// instance with SETTLE=3 is checked directly for timing and hold length.
module tb_lab3_sweep;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start3;
  logic [15:0] expected, expected3;
  logic        in_g, in_g3;
  logic        w, x, y, z, w3, x3, y3, z3;
  logic        busy, done, mismatch, busy3, done3, mismatch3;
  logic [15:0] captured, captured3;
  logic [4:0]  err_count, err_count3;
  logic [3:0]  first_err_idx, first_err_idx3;

  always #5 clk = ~clk;

  assign in_g  = w ^ x ^ y ^ z;
  assign in_g3 = w3 ^ x3 ^ y3 ^ z3;

  lab3_sweep #(.SETTLE(1)) dut1 (
    .CL2947MP_clk(clk), .CL2947MP_rst(rst), .CL2947MP_start(start),
    .CL2947MP_expected(expected), .CL2947MP_in_g(in_g),
    .CL2947MP_w(w), .CL2947MP_x(x), .CL2947MP_y(y), .CL2947MP_z(z),
    .CL2947MP_busy(busy), .CL2947MP_done(done), .CL2947MP_captured(captured),
    .CL2947MP_err_count(err_count), .CL2947MP_first_err_idx(first_err_idx),
    .CL2947MP_mismatch(mismatch)
  );

  lab3_sweep #(.SETTLE(3)) dut3 (
    .CL2947MP_clk(clk), .CL2947MP_rst(rst), .CL2947MP_start(start3),
    .CL2947MP_expected(expected3), .CL2947MP_in_g(in_g3),
    .CL2947MP_w(w3), .CL2947MP_x(x3), .CL2947MP_y(y3), .CL2947MP_z(z3),
    .CL2947MP_busy(busy3), .CL2947MP_done(done3), .CL2947MP_captured(captured3),
    .CL2947MP_err_count(err_count3), .CL2947MP_first_err_idx(first_err_idx3),
    .CL2947MP_mismatch(mismatch3)
  );

  typedef struct {
    logic [15:0] cap;
    logic [4:0]  err;
    logic [3:0]  first;
    logic        mm;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc     = 0;
  int   acc_cyc = 0;

  // Count rising edges so latencies can be measured in cycles.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("captured", {16'd0, captured}, {16'd0, e.cap});
        check("err_count", {27'd0, err_count}, {27'd0, e.err});
        check("first_err_idx", {28'd0, first_err_idx}, {28'd0, e.first});
        check("mismatch", {31'd0, mismatch}, {31'd0, e.mm});
        // done seen here is sampled by the next rising edge.
        check("done_latency", cyc + 1 - acc_cyc, e.lat);
      end
    end
  end

  // Issue one sweep on the SETTLE=1 instance and queue its expected result.
  task automatic start_sweep(input logic [15:0] e, input logic [15:0] cap,
                             input logic [4:0] err, input logic [3:0] first,
                             input logic mm, input int lat);
    exp_t item;
    item.cap = cap; item.err = err; item.first = first; item.mm = mm; item.lat = lat;
    @(negedge clk);
    start    = 1'b1;
    expected = e;
    sb_q.push_back(item);
    @(posedge clk);
    #1 acc_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) until the queued sweep completed and the DUT is idle.
  task automatic wait_idle();
    int n = 0;
    while ((sb_q.size() != 0 || busy !== 1'b0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("sweep_finished", {31'd0, (n < 300)}, 32'd1);
    if (n >= 300) sb_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_wxyz"}, {28'd0, w, x, y, z}, 32'd0);
    check({tag, "_captured"}, {16'd0, captured}, 32'd0);
    check({tag, "_err_count"}, {27'd0, err_count}, 32'd0);
    check({tag, "_first_err_idx"}, {28'd0, first_err_idx}, 32'd0);
    check({tag, "_mismatch"}, {31'd0, mismatch}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; start3 = 1'b0;
    expected = 16'h0000; expected3 = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Matching loopback: clean sweep.
    start_sweep(16'h6996, 16'h6996, 5'd0, 4'd0, 1'b0, 33);
    wait_idle();
    check("idle_wxyz", {28'd0, w, x, y, z}, 32'd0);

    // Single wrong golden bit at vector 0.
`ifdef LAB3_SWEEP_STOP_ON_ERR_EN
    start_sweep(16'h6997, 16'h0000, 5'd1, 4'd0, 1'b1, 3);
`else
    start_sweep(16'h6997, 16'h6996, 5'd1, 4'd0, 1'b1, 33);
`endif
    wait_idle();
    check("result_hold_err", {27'd0, err_count}, 32'd1);

    // All-zero golden table: every odd-parity vector mismatches.
`ifdef LAB3_SWEEP_STOP_ON_ERR_EN
    start_sweep(16'h0000, 16'h0002, 5'd1, 4'd1, 1'b1, 5);
`else
    start_sweep(16'h0000, 16'h6996, 5'd8, 4'd1, 1'b1, 33);
`endif
    wait_idle();

    // Start re-pulsed and golden table changed mid-sweep: both ignored.
    start_sweep(16'h6996, 16'h6996, 5'd0, 4'd0, 1'b0, 33);
    repeat (4) @(negedge clk);
    start    = 1'b1;
    expected = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    check("busy_mid_sweep", {31'd0, busy}, 32'd1);
    wait_idle();

    // Reset at T+10 discards the sweep; a new sweep then runs cleanly.
    start_sweep(16'h6996, 16'h6996, 5'd0, 4'd0, 1'b0, 33);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check_all_zero("midreset");
    rst = 1'b0;
    start_sweep(16'h6996, 16'h6996, 5'd0, 4'd0, 1'b0, 33);
    wait_idle();

    // SETTLE=3: each vector held 4 cycles, done sampled at T+65.
    @(negedge clk);
    start3    = 1'b1;
    expected3 = 16'h6996;
    @(posedge clk);
    #1 start3 = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      check("s3_vector", {28'd0, w3, x3, y3, z3}, k / 4);
      check("s3_no_early_done", {31'd0, done3}, 32'd0);
    end
    @(negedge clk);
    check("s3_done", {31'd0, done3}, 32'd1);
    check("s3_captured", {16'd0, captured3}, 32'h6996);
    check("s3_err_count", {27'd0, err_count3}, 32'd0);
    check("s3_mismatch", {31'd0, mismatch3}, 32'd0);
    @(negedge clk);
    check("s3_done_single", {31'd0, done3}, 32'd0);
    check("s3_idle", {31'd0, busy3}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
